arb_mux: RTL and testbench
==========================

# arb_mux

Parametrised N-to-1 registered multiplexer with a valid/ready handshake on every input channel and on the output. It supports two selection modes: a fixed select index or round-robin arbitration across the requesting channels. It is the successor to the combinational 16:1 operand mux. It sits between multiple 32-bit data producers (register-file read ports, forwarding sources, bus masters) and a single consumer. It gives the consumer one registered output stage and fair sharing between channels.

## Interface
- `WIDTH`, default 32: data width per channel.
- `N`, default 16: channel count, N ≥ 2.
- `SELW`, default `$clog2(N)`: width of the select and grant index.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_data` input N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid` input N: per-channel request.
- `in_ready` output N: per-channel accept, one-hot or zero, combinational.
- `mode` input 1: 0 selects fixed-select mode, 1 selects round-robin mode.
- `sel` input SELW: channel index used in fixed mode, ignored in round-robin mode.
- `out_data` output WIDTH: registered data.
- `out_sel` output SELW: index of the channel that supplied `out_data`.
- `out_valid` output 1: output register holds data.
- `out_ready` input 1: consumer accept.

## Operation
- **Output register state:** the block has a single output register slot with two states, EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- **Load condition:** `load` = (!`out_valid` || `out_ready`) && `req`. `req` is the logical OR over all eligible channels.
- **Fixed mode (`mode`=0):**
  - Channel `sel` is the only eligible channel.
  - Grant = `sel` if `in_valid[sel]`, otherwise there is no grant.
  - A `sel` value ≥ N gives no grant.
- **Round-robin mode (`mode`=1):**
  - Every channel with `in_valid`=1 is eligible.
  - The search starts at `last`+1 and wraps modulo N. The first eligible channel found is granted.
- **`in_ready`:** `in_ready[g]` = `load` for the granted channel g. All other bits are 0.
- **Transfer:** a transfer on channel g happens when `in_valid[g]` && `in_ready[g]`. On that edge:
  - `out_data` ← channel g data.
  - `out_sel` ← g.
  - `out_valid` ← 1.
  - `last` ← g. This update happens in both modes.
- **Output drain:** `out_valid` && `out_ready` with no new load sets `out_valid` ← 0. `out_data` and `out_sel` hold their last values.
- **Simultaneous drain and load:** the output register is overwritten with the new word and `out_valid` stays 1. The block sustains one word per cycle.
- **Holding while stalled:** while `out_valid`=1 and `out_ready`=0, all `in_ready` bits are 0. `out_data`, `out_sel` and `last` hold.
- **Mode or `sel` changes:** a change takes effect at the next grant evaluation. It never alters a word already held in the output register.
- **`last` pointer:** `last` is internal, SELW bits wide, and wraps after N-1.

## Timing
- **Reset values (asynchronous, while `rst_n`=0):**
  - `out_valid`=0.
  - `out_data`=0.
  - `out_sel`=0.
  - `last`=N-1, so the first round-robin search starts at channel 0.
  - `in_ready` is all zero, because `load` requires `req` and the arbitration gating is released only when `rst_n`=1.
- **Reset asserted mid-transfer:** the held word is discarded. No transfer completes on the edge where reset is asserted.
- **Latency:** one cycle from an accepted input to `out_valid`=1 with that data.
- **Throughput:** one word per clock while `out_ready`=1 and any eligible request exists.
- **Combinational paths:**
  - `in_ready` depends combinationally on `in_valid`, `mode`, `sel`, `out_valid` and `out_ready`.
  - No combinational path exists from `in_data` to any output.
- **Fairness:** with all N channels requesting continuously and `out_ready`=1 in round-robin mode, each channel is granted exactly once in every N consecutive cycles.

## Test plan
- **Reset and first grant:** assert `rst_n`=0 with all inputs requesting, then release. Expect `out_valid`=0 and `out_data`=0 during reset. Expect channel 0 to be granted on the first clock after release, then `out_sel`=0 and `out_data`=ch0 data on the following cycle.
- **Round-robin rotation:**
  - Setup: N=16, all 16 `in_valid`=1, `out_ready`=1, `mode`=1.
  - Expect `out_sel` to sequence 0,1,…,15,0 on consecutive cycles.
  - Expect each channel's `in_ready` to pulse once per 16 cycles.
- **Sparse round-robin:**
  - Setup: only channels 3, 7 and 12 valid.
  - Expect grants 3,7,12,3.
  - Then drop channel 7. Expect grants to continue as 12,3,12.
- **Fixed mode:**
  - Setup: `mode`=0, `sel`=5, channels 5 and 9 valid. Expect only channel 5 granted and `in_ready[9]`=0.
  - Set `sel`=9 while the output is FULL. The held data remains ch5 data until drained, then channel 9 is granted.
- **Backpressure:**
  - Hold `out_ready`=0 for 4 cycles after a load. Expect `out_data` and `out_sel` stable and `in_ready` all zero.
  - Raise `out_ready`. Expect a simultaneous drain and load in the same cycle with `out_valid` remaining 1.
- **Reset mid-stream:** assert `rst_n`=0 asynchronously between edges while `out_valid`=1. Expect `out_valid` to fall immediately and the round-robin to restart at channel 0 after release.

Source files
------------

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - N-to-1 registered valid/ready mux with fixed-select or round-robin grant
// One output slot; in_ready is gated off while reset is held so no word is accepted then.

module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 16,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SELW-1:0] last;
  logic [SELW-1:0] grant;
  logic            req;
  logic            load;
  int              rr_idx;

  always_comb begin
    req    = 1'b0;
    grant  = '0;
    rr_idx = 0;
    if (!mode) begin
      if (int'(sel) < N) begin
        req   = in_valid[sel];
        grant = sel;
      end
    end else begin
      // search from the channel after the last grant, wrapping modulo N
      for (int k = 1; k <= N; k++) begin
        rr_idx = (int'(last) + k) % N;
        if (!req && in_valid[SELW'(rr_idx)]) begin
          req   = 1'b1;
          grant = SELW'(rr_idx);
        end
      end
    end
  end

  assign load = rst_n && req && (!out_valid || out_ready);

  always_comb begin
    in_ready        = '0;
    in_ready[grant] = load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= SELW'(N - 1);
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant*WIDTH +: WIDTH];
      out_sel   <= grant;
      last      <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - scoreboard bench for arb_mux with a queue-based arbitration model
// Stimulus changes 1ns after posedge; the monitor checks the output slot on negedge.

module tb_arb_mux;

  localparam int WIDTH = 32;
  localparam int N     = 16;
  localparam int SELW  = 4;

  logic               clk       = 1'b0;
  logic               rst_n     = 1'b0;
  logic [N*WIDTH-1:0] in_data   = '0;
  logic [N-1:0]       in_valid  = '0;
  logic [N-1:0]       in_ready;
  logic               mode      = 1'b1;
  logic [SELW-1:0]    sel       = '0;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_valid;
  logic               out_ready = 1'b1;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [SELW-1:0]  ch;
    logic [WIDTH-1:0] data;
  } word_t;

  word_t sb[$];
  int    checks = 0;
  int    errors = 0;
  bit    m_valid = 1'b0;
  int    m_last = N - 1;
  bit    exp_valid = 1'b0;
  int    pulses[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant from the channel-selection rules: fixed index, or the lowest
  // requester above the previous grant, else the lowest requester overall.
  function automatic int model_grant();
    int cands[$];
    if (!rst_n) return -1;
    if (!mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    for (int c = 0; c < N; c++) if (in_valid[c]) cands.push_back(c);
    if (cands.size() == 0) return -1;
    foreach (cands[i]) if (cands[i] > m_last) return cands[i];
    return cands[0];
  endfunction

  task automatic cycle(input bit r, input bit m, input logic [SELW-1:0] s,
                       input logic [N-1:0] v, input bit ordy);
    int g;
    bit ld;
    logic [N-1:0] one;
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    #1;
    rst_n = r; mode = m; sel = s; in_valid = v; out_ready = ordy;
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
    #1;
    exp_valid = m_valid;
    g  = model_grant();
    ld = (g >= 0) && (!m_valid || ordy);
    one = 1;
    exp_rdy = ld ? (one << g) : '0;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    for (int i = 0; i < N; i++) if (in_ready[i]) pulses[i]++;
    if (ld) begin
      sb.push_back({SELW'(g), in_data[g*WIDTH +: WIDTH]});
      m_valid = 1'b1;
      m_last  = g;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    if (!r) begin
      m_valid = 1'b0;
      m_last  = N - 1;
      sb.delete();
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    sb.delete();
    m_valid   = 1'b0;
    m_last    = N - 1;
    exp_valid = 1'b0;
    #1;
    check("async_reset_valid", 64'(out_valid), 64'd0);
    check("async_reset_data", 64'(out_data), 64'd0);
    check("async_reset_sel", 64'(out_sel), 64'd0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      check("out_valid", 64'(out_valid), 64'(exp_valid));
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got out_sel=%0d with no expected word at %0t", out_sel, $time);
        end else begin
          check("out_sel", 64'(out_sel), 64'(sb[0].ch));
          check("out_data", 64'(out_data), 64'(sb[0].data));
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] sparse;
    logic [N-1:0] fixed_v;
    sparse  = (16'd1 << 3) | (16'd1 << 7) | (16'd1 << 12);
    fixed_v = (16'd1 << 5) | (16'd1 << 9);

    repeat (3) cycle(1'b0, 1'b1, 4'd0, '1, 1'b1);
    check("reset_data", 64'(out_data), 64'd0);
    check("reset_sel", 64'(out_sel), 64'd0);

    foreach (pulses[i]) pulses[i] = 0;
    repeat (32) cycle(1'b1, 1'b1, 4'd0, '1, 1'b1);
    for (int i = 0; i < N; i++) check($sformatf("fair_ch%0d", i), 64'(pulses[i]), 64'd2);

    repeat (4) cycle(1'b1, 1'b1, 4'd0, sparse, 1'b1);
    sparse[7] = 1'b0;
    repeat (4) cycle(1'b1, 1'b1, 4'd0, sparse, 1'b1);

    repeat (3) cycle(1'b1, 1'b0, 4'd5, fixed_v, 1'b1);
    repeat (4) cycle(1'b1, 1'b0, 4'd9, fixed_v, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 4'd9, fixed_v, 1'b1);

    repeat (4) cycle(1'b1, 1'b1, 4'd0, '1, 1'b0);
    repeat (3) cycle(1'b1, 1'b1, 4'd0, '1, 1'b1);

    repeat (400) cycle(1'b1, 1'($urandom), 4'($urandom), 16'($urandom & $urandom),
                       $urandom_range(0, 3) != 0);

    cycle(1'b1, 1'b1, 4'd0, '1, 1'b0);
    cycle(1'b1, 1'b1, 4'd0, '1, 1'b0);
    mid_reset();
    cycle(1'b0, 1'b1, 4'd0, '1, 1'b1);
    cycle(1'b1, 1'b1, 4'd0, '1, 1'b1);
    check("restart_grant_ch0", 64'(in_ready), 64'd1);
    repeat (6) cycle(1'b1, 1'b1, 4'd0, '1, 1'b1);
    repeat (2) cycle(1'b1, 1'b1, 4'd0, '0, 1'b1);

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
